pc_sequence_controller: RTL and testbench

PC_SEQUENCE_CONTROLLER -- requirements
Module: pc_sequence_controller

---
 rtl/pc_sequence_controller.sv | 75 +++++++
 tb/tb_pc_sequence_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_sequence_controller.sv
// pc_sequence_controller: fetch/decode/execute timing FSM for a small accumulator CPU.
// It drives the program-counter strobes, the fetch strobes and the T0..T3 timing step.
module pc_sequence_controller #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_clock,
   input  logic                  RST_reset,
   input  logic                  S_start,
   input  logic [2:0]            IR_opcode,
   input  logic [ADDR_WIDTH-1:0] IR_addr,
   input  logic                  AC_zero,
   output logic                  PC_INR,
   output logic                  PC_LD,
   output logic                  PC_CLR,
   output logic [ADDR_WIDTH-1:0] PC_input,
   output logic                  AR_LD,
   output logic                  MEM_RD,
   output logic                  IR_LD,
   output logic [1:0]            T_timing,
   output logic                  halted
);
   typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, DECODE, EXEC, HALT} state_t;
   localparam logic [2:0] OP_BUN = 3'b001;
   localparam logic [2:0] OP_SZA = 3'b010;
   localparam logic [2:0] OP_HLT = 3'b011;
   localparam logic [2:0] OP_CLP = 3'b100;
   state_t     state;
   logic [2:0] op_q;
   // EXEC strobes are registered while leaving DECODE so they line up with T=3;
   // op_q keeps the decoded opcode for the EXEC exit decision.
   always_ff @(posedge clk_clock) begin
      if (RST_reset) begin
         state    <= IDLE;
         op_q     <= '0;
         PC_input <= '0;
         T_timing <= '0;
         {PC_INR, PC_LD, PC_CLR, AR_LD, MEM_RD, IR_LD, halted} <= '0;
      end else begin
         {PC_INR, PC_LD, PC_CLR, AR_LD, MEM_RD, IR_LD} <= '0;
         unique case (state)
            IDLE, HALT: if (S_start) begin
               state    <= FETCH0;
               AR_LD    <= 1'b1;
               halted   <= 1'b0;
               T_timing <= 2'd0;
            end
            FETCH0: begin
               state    <= FETCH1;
               {MEM_RD, IR_LD, PC_INR} <= '1;
               T_timing <= 2'd1;
            end
            FETCH1: begin
               state    <= DECODE;
               T_timing <= 2'd2;
            end
            DECODE: begin
               state    <= EXEC;
               T_timing <= 2'd3;
               op_q     <= IR_opcode;
               PC_LD    <= IR_opcode == OP_BUN;
               PC_INR   <= IR_opcode == OP_SZA && AC_zero;
               PC_CLR   <= IR_opcode == OP_CLP;
               PC_input <= IR_opcode == OP_BUN ? IR_addr : PC_input;
            end
            EXEC: begin
               T_timing <= 2'd0;
               state    <= op_q == OP_HLT ? HALT : FETCH0;
               halted   <= op_q == OP_HLT;
               AR_LD    <= op_q != OP_HLT;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pc_sequence_controller.sv
// tb_pc_sequence_controller: directed stimulus with an instruction-phase model and bench PC.
// Outputs are compared against the model on every falling edge after the first reset.
module tb_pc_sequence_controller;
   logic       clk_clock = 0, RST_reset, S_start, AC_zero;
   logic [2:0] IR_opcode;
   logic [3:0] IR_addr, PC_input;
   logic       PC_INR, PC_LD, PC_CLR, AR_LD, MEM_RD, IR_LD, halted;
   logic [1:0] T_timing;
   int n_tests = 0, n_fail = 0;
   pc_sequence_controller #(.ADDR_WIDTH(4)) dut (
      .clk_clock(clk_clock), .RST_reset(RST_reset), .S_start(S_start),
      .IR_opcode(IR_opcode), .IR_addr(IR_addr), .AC_zero(AC_zero),
      .PC_INR(PC_INR), .PC_LD(PC_LD), .PC_CLR(PC_CLR), .PC_input(PC_input),
      .AR_LD(AR_LD), .MEM_RD(MEM_RD), .IR_LD(IR_LD), .T_timing(T_timing), .halted(halted));
   always #5 clk_clock = ~clk_clock;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask
   // Model: ph = step within an instruction (0..3), -1 idle, -2 halted.
   int ph = -1, pc = 0;
   logic [2:0] m_op = 0;
   logic [3:0] m_addr = 0, e_pcin = 0;
   logic m_z = 0, armed = 0;
   always @(posedge clk_clock) begin
      if (PC_CLR === 1'b1) pc = 0;
      else if (PC_LD === 1'b1) pc = int'(PC_input);
      else if (PC_INR === 1'b1) pc = (pc + 1) % 16;
      if (RST_reset) begin
         ph = -1; e_pcin = 0; pc = 0; armed = 1;
      end else if (ph < 0) ph = S_start ? 0 : ph;
      else if (ph == 2) begin
         m_op = IR_opcode; m_addr = IR_addr; m_z = AC_zero; ph = 3;
         if (m_op == 3'd1) e_pcin = m_addr;
      end else if (ph == 3) ph = m_op == 3'd3 ? -2 : 0;
      else ph++;
   end
   logic p_inr = 0, p_ld = 0, p_clr = 0;
   always @(negedge clk_clock) if (armed) begin
      chk("T_timing", T_timing, ph >= 0 ? ph : 0);
      chk("halted", halted, ph == -2);
      chk("AR_LD", AR_LD, ph == 0);
      chk("MEM_RD", MEM_RD, ph == 1);
      chk("IR_LD", IR_LD, ph == 1);
      chk("PC_INR", PC_INR, ph == 1 || (ph == 3 && m_op == 3'd2 && m_z));
      chk("PC_LD", PC_LD, ph == 3 && m_op == 3'd1);
      chk("PC_CLR", PC_CLR, ph == 3 && m_op == 3'd4);
      chk("PC_input", PC_input, e_pcin);
      chk("pc_strobe_onehot", 32'(PC_INR) + 32'(PC_LD) + 32'(PC_CLR) <= 1, 1);
      chk("pc_strobe_repeat", (PC_INR & p_inr) | (PC_LD & p_ld) | (PC_CLR & p_clr), 0);
      {p_inr, p_ld, p_clr} = {PC_INR, PC_LD, PC_CLR};
   end
   logic [1:0] r_t[4];
   logic [3:0] r_pcin[4];
   logic       r_inr[4], r_ld[4], r_clr[4], r_halt[4];
   // Called while the DUT shows FETCH0; the real fields are present only for the DECODE sample.
   task automatic instr(input logic [2:0] op, input logic [3:0] a, input logic z);
      for (int k = 0; k < 4; k++) begin
         if (k == 2) {IR_opcode, IR_addr, AC_zero} = {op, a, z};
         else {IR_opcode, IR_addr, AC_zero} = 8'($urandom);
         @(negedge clk_clock);
         {r_t[k], r_pcin[k], r_inr[k], r_ld[k], r_clr[k], r_halt[k]} =
            {T_timing, PC_input, PC_INR, PC_LD, PC_CLR, halted};
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      RST_reset = 1; S_start = 1; IR_opcode = 0; IR_addr = 0; AC_zero = 0;
      repeat (3) @(negedge clk_clock);
      chk("rst_AR_LD", AR_LD, 0);
      chk("rst_T", T_timing, 0);
      chk("rst_PC_input", PC_input, 0);
      RST_reset = 0;
      @(negedge clk_clock);
      chk("start_AR_LD", AR_LD, 1);
      S_start = 0;
      instr(3'd0, 4'h0, 0);
      chk("nop_T_seq", {r_t[0], r_t[1], r_t[2], r_t[3]}, 8'b01_10_11_00);
      chk("nop_inr", {r_inr[0], r_inr[1], r_inr[2], r_inr[3]}, 4'b1000);
      instr(3'd5, 4'h3, 1);
      chk("op5_inr", {r_inr[0], r_inr[1], r_inr[2], r_inr[3]}, 4'b1000);
      chk("pc_after_nops", pc, 2);
      instr(3'd1, 4'hA, 0);
      chk("bun_ld", r_ld[2], 1);
      chk("bun_pcin", r_pcin[2], 4'hA);
      chk("bun_inr_t3", r_inr[2], 0);
      chk("pc_after_bun", pc, 10);
      instr(3'd0, 4'h0, 0);
      chk("pcin_hold", r_pcin[3], 4'hA);
      S_start = 1;
      instr(3'd2, 4'h6, 1);
      S_start = 0;
      chk("sza1_inr", {r_inr[0], r_inr[1], r_inr[2], r_inr[3]}, 4'b1010);
      chk("pc_after_sza1", pc, 13);
      instr(3'd2, 4'h6, 0);
      chk("sza0_inr", {r_inr[0], r_inr[1], r_inr[2], r_inr[3]}, 4'b1000);
      instr(3'd4, 4'h0, 0);
      chk("clp_clr", {r_clr[0], r_clr[1], r_clr[2], r_clr[3]}, 4'b0010);
      chk("pc_after_clp", pc, 0);
      instr(3'd0, 4'h0, 0);
      chk("pc_after_clp_fetch", pc, 1);
      instr(3'd3, 4'h0, 0);
      chk("hlt_halted", r_halt[3], 1);
      chk("hlt_T", r_t[3], 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_clock);
         chk("halt_quiet", {halted, AR_LD, MEM_RD, PC_INR, PC_LD, PC_CLR}, 6'b100000);
      end
      S_start = 1;
      @(negedge clk_clock);
      chk("restart", {halted, AR_LD, T_timing}, 4'b0100);
      S_start = 0;
      IR_opcode = 3'd1; IR_addr = 4'h5; AC_zero = 0;
      repeat (2) @(negedge clk_clock);
      RST_reset = 1; S_start = 1;
      @(negedge clk_clock);
      chk("rst_exec_ld", PC_LD, 0);
      chk("rst_exec_pcin", PC_input, 0);
      chk("rst_exec_T", T_timing, 0);
      repeat (2) begin
         @(negedge clk_clock);
         chk("rst_hold_start", AR_LD, 0);
      end
      RST_reset = 0;
      @(negedge clk_clock);
      chk("rst_release_start", AR_LD, 1);
      S_start = 0;
      instr(3'd0, 4'h0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
